// File: rtl/result_bus_arbiter_pkg.sv
// Shared writeback types and sequence-number helpers for the result-bus arbiter,
// reservation station and LSU.
package result_bus_arbiter_pkg;

  localparam int unsigned SQN_W  = 6;
  localparam int unsigned TAG_W  = 7;
  localparam int unsigned NM_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [SQN_W-1:0]  sqN;
    logic [TAG_W-1:0]  tagDst;
    logic [NM_W-1:0]   nmDst;
    logic [DATA_W-1:0] result;
  } RES_UOp;

  // a is older than b across the SQN_W-bit wrap-around
  function automatic logic sqn_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  // true when sqN is strictly younger than the last surviving op
  function automatic logic sqn_killed(input logic [SQN_W-1:0] sqN, input logic [SQN_W-1:0] lastSqN);
    logic [SQN_W-1:0] d;
    d = sqN - lastSqN;
    return !d[SQN_W-1] && (d != '0);
  endfunction

endpackage

// File: rtl/result_bus_arbiter_if.sv
// Writeback request / result bus bundle between the functional units and the arbiter.
interface result_bus_arbiter_if
  import result_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_BUS = 3
);
  logic [NUM_REQ-1:0]         IN_valid;
  RES_UOp [NUM_REQ-1:0]       IN_uop;
  logic [NUM_REQ-1:0]         OUT_stall;
  logic                       IN_invalidate;
  logic [SQN_W-1:0]           IN_invalidateSqN;
  logic [NUM_BUS-1:0]         OUT_resultValid;
  RES_UOp [NUM_BUS-1:0]       OUT_resultUOp;
  logic [15:0]                OUT_conflictCnt;

  modport master (
    output IN_valid, IN_uop, IN_invalidate, IN_invalidateSqN,
    input  OUT_stall, OUT_resultValid, OUT_resultUOp, OUT_conflictCnt
  );

  modport slave (
    input  IN_valid, IN_uop, IN_invalidate, IN_invalidateSqN,
    output OUT_stall, OUT_resultValid, OUT_resultUOp, OUT_conflictCnt
  );
endinterface

// File: rtl/result_bus_arbiter_age_select.sv
// Combinational comparison tree returning the index of the oldest masked candidate.
module result_bus_arbiter_age_select
  import result_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SQN_W-1:0]   sqN [NUM_REQ],
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  localparam int unsigned LEAVES = 1 << $clog2(NUM_REQ);

  always_comb begin
    logic             nodeV   [2*LEAVES];
    logic [SQN_W-1:0] nodeSq  [2*LEAVES];
    logic [IDX_W-1:0] nodeIdx [2*LEAVES];
    for (int unsigned n = 0; n < 2*LEAVES; n++) begin
      nodeV[n]   = 1'b0;
      nodeSq[n]  = '0;
      nodeIdx[n] = '0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      nodeV[LEAVES+i]   = mask[i];
      nodeSq[LEAVES+i]  = sqN[i];
      nodeIdx[LEAVES+i] = IDX_W'(i);
    end
    // Left subtree always holds lower indices, so keeping left on a tie gives lowest-index priority
    for (int unsigned n = LEAVES - 1; n >= 1; n--) begin
      if (nodeV[2*n+1] && (!nodeV[2*n] || sqn_older(nodeSq[2*n+1], nodeSq[2*n]))) begin
        nodeV[n]   = 1'b1;
        nodeSq[n]  = nodeSq[2*n+1];
        nodeIdx[n] = nodeIdx[2*n+1];
      end else begin
        nodeV[n]   = nodeV[2*n];
        nodeSq[n]  = nodeSq[2*n];
        nodeIdx[n] = nodeIdx[2*n];
      end
    end
    found = nodeV[1];
    idx   = nodeIdx[1];
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Grants up to NUM_BUS writeback results per cycle, oldest first, with a one-entry
// holding slot per requester for results that lose arbitration.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_BUS = 3
) (
  input logic              clk,
  input logic              rst,
  result_bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   slotValid;
  RES_UOp [NUM_REQ-1:0] slotUop;
  RES_UOp [NUM_REQ-1:0] candUop;
  logic [SQN_W-1:0]     candSqN [NUM_REQ];
  logic [NUM_REQ-1:0]   live;
  logic [NUM_BUS-1:0]   grantValid;
  logic [IDX_W-1:0]     grantIdx [NUM_BUS];
  logic [NUM_REQ-1:0]   leftover;
  logic [NUM_REQ-1:0]   granted;
  logic [NUM_BUS-1:0]   resultValid;
  RES_UOp [NUM_BUS-1:0] resultUOp;
  logic [15:0]          conflictCnt;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      candUop[i] = slotValid[i] ? slotUop[i] : bus.IN_uop[i];
      candSqN[i] = candUop[i].sqN;
      live[i]    = (slotValid[i] | bus.IN_valid[i])
                 & ~(bus.IN_invalidate & sqn_killed(candUop[i].sqN, bus.IN_invalidateSqN));
    end
  end

  // Each stage picks the oldest remaining candidate and removes it from the next stage's mask
  for (genvar b = 0; b < NUM_BUS; b++) begin : gStage
    logic [NUM_REQ-1:0] maskIn;
    logic [NUM_REQ-1:0] maskOut;
    logic               sel;
    logic [IDX_W-1:0]   idx;
    if (b == 0) begin : gFirst
      assign maskIn = live;
    end else begin : gNext
      assign maskIn = gStage[b-1].maskOut;
    end
    result_bus_arbiter_age_select #(.NUM_REQ(NUM_REQ)) uSel (
      .mask  (maskIn),
      .sqN   (candSqN),
      .found (sel),
      .idx   (idx)
    );
    assign maskOut       = sel ? (maskIn & ~(NUM_REQ'(1) << idx)) : maskIn;
    assign grantValid[b] = sel;
    assign grantIdx[b]   = idx;
  end

  assign leftover = gStage[NUM_BUS-1].maskOut;
  assign granted  = live & ~leftover;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotValid   <= '0;
      slotUop     <= '0;
      resultValid <= '0;
      resultUOp   <= '0;
      conflictCnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slotValid[i] <= live[i] & ~granted[i];
        if (live[i] && !granted[i]) slotUop[i] <= candUop[i];
      end
      for (int unsigned b = 0; b < NUM_BUS; b++) begin
        resultValid[b] <= grantValid[b];
        resultUOp[b]   <= candUop[grantIdx[b]];
      end
      if ((leftover != '0) && (conflictCnt != '1)) conflictCnt <= conflictCnt + 16'd1;
    end
  end

  assign bus.OUT_stall       = slotValid;
  assign bus.OUT_resultValid = resultValid;
  assign bus.OUT_resultUOp   = resultUOp;
  assign bus.OUT_conflictCnt = conflictCnt;

  noValidWhileStalled: assert property (@(posedge clk) disable iff (rst) (bus.IN_valid & slotValid) == '0);

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench: vector table on a 3-bus arbiter plus wrap/tie/reset sequences
// on 3-bus and 1-bus instances.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_bus_arbiter_if #(.NUM_REQ(4), .NUM_BUS(3)) ifA();
  result_bus_arbiter_if #(.NUM_REQ(4), .NUM_BUS(1)) ifB();

  result_bus_arbiter #(.NUM_REQ(4), .NUM_BUS(3)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  result_bus_arbiter #(.NUM_REQ(4), .NUM_BUS(1)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  typedef struct packed {
    logic [3:0]      valid;
    logic [3:0][5:0] sqn;
    logic            inv;
    logic [5:0]      invSqn;
    logic [2:0]      expBv;
    logic [2:0][5:0] expSq;
    logic [3:0]      expStall;
    logic [15:0]     expCnt;
  } vec_t;

  typedef struct packed {
    logic [2:0]      bv;
    logic [2:0][5:0] sq;
    logic [3:0]      stall;
    logic [15:0]     cnt;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nErr    = 0;

  function automatic vec_t mk(input logic [3:0] v, input int s0, input int s1, input int s2, input int s3,
                              input logic inv, input int invS, input logic [2:0] bv,
                              input int b0, input int b1, input int b2, input logic [3:0] st, input int cnt);
    vec_t r;
    r.valid    = v;
    r.sqn      = {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
    r.inv      = inv;
    r.invSqn   = 6'(invS);
    r.expBv    = bv;
    r.expSq    = {6'(b2), 6'(b1), 6'(b0)};
    r.expStall = st;
    r.expCnt   = 16'(cnt);
    return r;
  endfunction

  function automatic logic [31:0] payOf(input logic [5:0] s);
    return {16'hC0DE, 2'b00, s, 2'b00, s};
  endfunction

  function automatic RES_UOp mkUop(input int idx, input logic [5:0] s);
    RES_UOp u;
    u.sqN    = s;
    u.tagDst = 7'(idx);
    u.nmDst  = 5'(idx);
    u.result = payOf(s);
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic driveA(input vec_t v);
    ifA.IN_valid         = v.valid;
    ifA.IN_invalidate    = v.inv;
    ifA.IN_invalidateSqN = v.invSqn;
    for (int i = 0; i < 4; i++)
      ifA.IN_uop[i] = v.valid[i] ? mkUop(i, v.sqn[i]) : '0;
  endtask

  task automatic driveB(input logic [3:0] v, input int s0, input int s1, input int s2, input int s3);
    logic [3:0][5:0] s;
    s = {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
    ifB.IN_valid         = v;
    ifB.IN_invalidate    = 1'b0;
    ifB.IN_invalidateSqN = '0;
    for (int i = 0; i < 4; i++)
      ifB.IN_uop[i] = v[i] ? mkUop(i, s[i]) : '0;
  endtask

  task automatic applyRow(input vec_t v, input string tag);
    exp_t e;
    driveA(v);
    expQ.push_back('{bv: v.expBv, sq: v.expSq, stall: v.expStall, cnt: v.expCnt});
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    check({tag, ".busValid"}, 64'(ifA.OUT_resultValid), 64'(e.bv));
    for (int b = 0; b < 3; b++) begin
      if (e.bv[b]) begin
        check($sformatf("%s.bus%0d.sqN", tag, b), 64'(ifA.OUT_resultUOp[b].sqN), 64'(e.sq[b]));
        check($sformatf("%s.bus%0d.result", tag, b), 64'(ifA.OUT_resultUOp[b].result), 64'(payOf(e.sq[b])));
      end
    end
    check({tag, ".stall"}, 64'(ifA.OUT_stall), 64'(e.stall));
    check({tag, ".conflictCnt"}, 64'(ifA.OUT_conflictCnt), 64'(e.cnt));
  endtask

  task automatic stepCheckB(input string tag, input logic bv, input int sq, input int tagDst, input logic [3:0] st);
    @(posedge clk);
    #1;
    check({tag, ".busValid"}, 64'(ifB.OUT_resultValid), 64'(bv));
    if (bv) begin
      check({tag, ".sqN"}, 64'(ifB.OUT_resultUOp[0].sqN), 64'(sq));
      check({tag, ".tagDst"}, 64'(ifB.OUT_resultUOp[0].tagDst), 64'(tagDst));
    end
    check({tag, ".stall"}, 64'(ifB.OUT_stall), 64'(st));
  endtask

  vec_t vecs[10];
  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle = mk(4'b0000, 0, 0, 0, 0, 1'b0, 0, 3'b000, 0, 0, 0, 4'b0000, 0);
    vecs[0] = mk(4'b0101,  5,  0,  3,  0, 1'b0,  0, 3'b011,  3,  5,  0, 4'b0000, 0);
    vecs[1] = mk(4'b1111, 10, 11, 12, 13, 1'b0,  0, 3'b111, 10, 11, 12, 4'b1000, 1);
    vecs[2] = mk(4'b0000,  0,  0,  0,  0, 1'b0,  0, 3'b001, 13,  0,  0, 4'b0000, 1);
    vecs[3] = mk(4'b1111,  7,  4,  6,  5, 1'b0,  0, 3'b111,  4,  5,  6, 4'b0001, 2);
    vecs[4] = mk(4'b1110,  0, 30, 31, 29, 1'b0,  0, 3'b111,  7, 29, 30, 4'b0100, 3);
    vecs[5] = mk(4'b0011, 25, 40,  0,  0, 1'b1, 30, 3'b001, 25,  0,  0, 4'b0000, 3);
    vecs[6] = mk(4'b1111, 60, 63,  2,  1, 1'b0,  0, 3'b111, 60, 63,  1, 4'b0100, 4);
    vecs[7] = mk(4'b1011,  3,  4,  0,  5, 1'b0,  0, 3'b111,  2,  3,  4, 4'b1000, 5);
    vecs[8] = mk(4'b0111,  6,  7,  8,  0, 1'b0,  0, 3'b111,  5,  6,  7, 4'b0100, 6);
    vecs[9] = mk(4'b0000,  0,  0,  0,  0, 1'b0,  0, 3'b001,  8,  0,  0, 4'b0000, 6);

    driveA(idle);
    driveB(4'b0000, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.A.busValid", 64'(ifA.OUT_resultValid), 64'd0);
    check("reset.A.stall", 64'(ifA.OUT_stall), 64'd0);
    check("reset.A.conflictCnt", 64'(ifA.OUT_conflictCnt), 64'd0);
    check("reset.B.busValid", 64'(ifB.OUT_resultValid), 64'd0);
    rst = 1'b0;

    for (int r = 0; r < 10; r++) applyRow(vecs[r], $sformatf("row%0d", r));

    // invalidate: slot 20 and incoming 21 die, 15 survives
    applyRow(mk(4'b1111, 17, 18, 19, 20, 1'b0, 0, 3'b111, 17, 18, 19, 4'b1000, 7), "invSetup");
    applyRow(mk(4'b0011, 21, 15, 0, 0, 1'b1, 18, 3'b001, 15, 0, 0, 4'b0000, 7), "invFlush");
    applyRow(mk(4'b0000, 0, 0, 0, 0, 1'b0, 0, 3'b000, 0, 0, 0, 4'b0000, 7), "invAfter");

    // single bus: wrap-around age order
    driveB(4'b0011, 1, 62, 0, 0);
    stepCheckB("wrap.grant", 1'b1, 62, 1, 4'b0001);
    driveB(4'b0000, 0, 0, 0, 0);
    stepCheckB("wrap.slot", 1'b1, 1, 0, 4'b0000);
    stepCheckB("wrap.idle", 1'b0, 0, 0, 4'b0000);

    // single bus: equal sqN, lower index wins
    driveB(4'b1010, 0, 9, 0, 9);
    stepCheckB("tie.grant", 1'b1, 9, 1, 4'b1000);
    driveB(4'b0000, 0, 0, 0, 0);
    stepCheckB("tie.slot", 1'b1, 9, 3, 4'b0000);
    check("B.conflictCnt", 64'(ifB.OUT_conflictCnt), 64'd2);

    // asynchronous reset mid-cycle with a full slot and busy buses
    driveA(mk(4'b1111, 40, 41, 42, 43, 1'b0, 0, 3'b000, 0, 0, 0, 4'b0000, 0));
    @(posedge clk);
    #1;
    driveA(idle);
    check("preRst.busValid", 64'(ifA.OUT_resultValid), 64'h7);
    check("preRst.stall", 64'(ifA.OUT_stall), 64'h8);
    #3;
    rst = 1'b1;
    #1;
    check("midRst.busValid", 64'(ifA.OUT_resultValid), 64'd0);
    check("midRst.stall", 64'(ifA.OUT_stall), 64'd0);
    check("midRst.conflictCnt", 64'(ifA.OUT_conflictCnt), 64'd0);
    check("midRst.B.stall", 64'(ifB.OUT_stall), 64'd0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
